// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//
// Arbitrates between NUM_REQ load requesters and a single retiring-store
// requester for one dcache request slot. The winning request is captured into
// the dc_* output register and held until the dcache accepts it. A new request
// can be captured in the same cycle the held one is accepted, so there is no
// bubble between back-to-back transfers.
//
// Priority: the store wins unless it has beaten waiting loads STARVE_LIMIT
// times in a row. In that case a valid load wins. Loads are chosen
// round-robin, starting the search at rr_ptr.
//
// Ports
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   ld_req_*          : per-load request valid / address / func / LQ index
//   ld_gnt            : one-hot capture pulse back to the winning load
//   st_req_*          : store request valid / address / data / func
//   st_gnt            : capture pulse back to the store requester
//   dc_valid          : a request is being presented to the dcache
//   dc_is_store       : 1 = store, 0 = load
//   dc_addr/data/func : request payload (dc_data is 0 for loads)
//   dc_idx            : load-queue index (0 for stores)
//   dc_accept         : dcache takes the presented request this cycle
// -----------------------------------------------------------------------------

`ifndef NUM_FU_LOAD
`define NUM_FU_LOAD 3
`endif

`ifndef LOAD_Q_INDEX_WIDTH
`define LOAD_Q_INDEX_WIDTH 3
`endif

module mem_req_arbiter #(
  parameter int NUM_REQ      = `NUM_FU_LOAD,
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int FUNC_WIDTH   = 3,
  parameter int IDX_WIDTH    = `LOAD_Q_INDEX_WIDTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 ld_req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] ld_req_addr,
  input  logic [NUM_REQ-1:0][FUNC_WIDTH-1:0] ld_req_func,
  input  logic [NUM_REQ-1:0][IDX_WIDTH-1:0]  ld_req_idx,
  output logic [NUM_REQ-1:0]                 ld_gnt,
  input  logic                               st_req_valid,
  input  logic [ADDR_WIDTH-1:0]              st_req_addr,
  input  logic [DATA_WIDTH-1:0]              st_req_data,
  input  logic [FUNC_WIDTH-1:0]              st_req_func,
  output logic                               st_gnt,
  output logic                               dc_valid,
  output logic                               dc_is_store,
  output logic [ADDR_WIDTH-1:0]              dc_addr,
  output logic [DATA_WIDTH-1:0]              dc_data,
  output logic [FUNC_WIDTH-1:0]              dc_func,
  output logic [IDX_WIDTH-1:0]               dc_idx,
  input  logic                               dc_accept
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   starve_cnt;

  logic               slot_free;
  logic               any_ld;
  logic               load_wins;
  logic               store_wins;
  logic               grant_ld;
  logic               grant_st;
  logic               ld_found;
  logic [PTR_W-1:0]   ld_sel;
  logic [PTR_W-1:0]   cand;

  // The slot can take a new request when nothing is held, or when the held
  // request leaves this cycle. dc_accept is irrelevant in IDLE.
  assign slot_free = (state_q == IDLE) || dc_accept;
  assign any_ld    = |ld_req_valid;

  // Loads win outright when no store is pending, or when the store has
  // starved them for STARVE_LIMIT consecutive grants.
  assign load_wins  = any_ld && (!st_req_valid || (starve_cnt == STARVE_MAX));
  assign store_wins = st_req_valid && !load_wins;

  assign grant_ld = slot_free && load_wins;
  assign grant_st = slot_free && store_wins;

  assign dc_valid = (state_q == HOLD);

  // Round-robin search: visit indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ and
  // keep the first valid one. This yields the lowest valid index >= rr_ptr,
  // otherwise the lowest valid index below it.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    ld_found = 1'b0;
    ld_sel   = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!ld_found && ld_req_valid[cand]) begin
        ld_found = 1'b1;
        ld_sel   = cand;
      end
    end
  end

  // Grants are combinational pulses in the capture cycle only; they are
  // forced low while reset is high so a requester never sees a phantom
  // consumption during reset.
  always_comb begin
    ld_gnt = '0;
    st_gnt = 1'b0;
    if (!reset) begin
      if (grant_ld && ld_found) begin
        ld_gnt = NUM_REQ'(1) << ld_sel;
      end
      st_gnt = grant_st;
    end
  end

  // Next-state logic. When the slot is not free the held request stays put.
  always_comb begin
    state_d = state_q;
    if (slot_free) begin
      state_d = (grant_ld || grant_st) ? HOLD : IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr      <= '0;
      starve_cnt  <= '0;
      dc_is_store <= 1'b0;
      dc_addr     <= '0;
      dc_data     <= '0;
      dc_func     <= '0;
      dc_idx      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_ld) begin
        dc_is_store <= 1'b0;
        dc_addr     <= ld_req_addr[ld_sel];
        dc_data     <= '0;
        dc_func     <= ld_req_func[ld_sel];
        dc_idx      <= ld_req_idx[ld_sel];
        rr_ptr      <= (ld_sel == LAST_IDX) ? '0 : ld_sel + 1'b1;
        starve_cnt  <= '0;
      end else if (grant_st) begin
        dc_is_store <= 1'b1;
        dc_addr     <= st_req_addr;
        dc_data     <= st_req_data;
        dc_func     <= st_req_func;
        dc_idx      <= '0;
        // Only count wins that actually held a load back.
        if (any_ld && (starve_cnt != STARVE_MAX)) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
//
// Directed bench for mem_req_arbiter with NUM_REQ=3, STARVE_LIMIT=4.
// Each expected dcache request is pushed to a queue when its grant is
// expected; a monitor pops and compares whenever the DUT hands a request to
// the dcache (dc_valid && dc_accept). Grants and a few held-register values
// are checked directly by the stimulus thread.
// -----------------------------------------------------------------------------

`ifndef NUM_FU_LOAD
`define NUM_FU_LOAD 3
`endif

`ifndef LOAD_Q_INDEX_WIDTH
`define LOAD_Q_INDEX_WIDTH 3
`endif

module tb_mem_req_arbiter;

  localparam int NR = 3;
  localparam int IW = `LOAD_Q_INDEX_WIDTH;

  typedef struct packed {
    logic          is_store;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [2:0]    func;
    logic [IW-1:0] idx;
  } item_t;

  localparam logic [31:0] ST_ADDR = 32'h0000_0200;
  localparam logic [31:0] ST_DATA = 32'hDEAD_BEEF;
  localparam logic [2:0]  ST_FUNC = 3'd2;

  // Grant codes: {st_gnt, ld_gnt[2:0]}
  localparam logic [3:0] G_L0 = 4'h1;
  localparam logic [3:0] G_L1 = 4'h2;
  localparam logic [3:0] G_L2 = 4'h4;
  localparam logic [3:0] G_S  = 4'h8;
  localparam logic [3:0] G_NO = 4'h0;

  logic                  clock;
  logic                  reset;
  logic [NR-1:0]         ld_req_valid;
  logic [NR-1:0][31:0]   ld_req_addr;
  logic [NR-1:0][2:0]    ld_req_func;
  logic [NR-1:0][IW-1:0] ld_req_idx;
  logic [NR-1:0]         ld_gnt;
  logic                  st_req_valid;
  logic [31:0]           st_req_addr;
  logic [31:0]           st_req_data;
  logic [2:0]            st_req_func;
  logic                  st_gnt;
  logic                  dc_valid;
  logic                  dc_is_store;
  logic [31:0]           dc_addr;
  logic [31:0]           dc_data;
  logic [2:0]            dc_func;
  logic [IW-1:0]         dc_idx;
  logic                  dc_accept;

  int    n_checks = 0;
  int    n_fail   = 0;
  item_t exp_q[$];

  mem_req_arbiter #(
    .NUM_REQ      (NR),
    .STARVE_LIMIT (4),
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .FUNC_WIDTH   (3),
    .IDX_WIDTH    (IW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ld_req_valid (ld_req_valid),
    .ld_req_addr  (ld_req_addr),
    .ld_req_func  (ld_req_func),
    .ld_req_idx   (ld_req_idx),
    .ld_gnt       (ld_gnt),
    .st_req_valid (st_req_valid),
    .st_req_addr  (st_req_addr),
    .st_req_data  (st_req_data),
    .st_req_func  (st_req_func),
    .st_gnt       (st_gnt),
    .dc_valid     (dc_valid),
    .dc_is_store  (dc_is_store),
    .dc_addr      (dc_addr),
    .dc_data      (dc_data),
    .dc_func      (dc_func),
    .dc_idx       (dc_idx),
    .dc_accept    (dc_accept)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] actual,
                       input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Hand-written request table for the three loads and the store.
  function automatic item_t exp_item(input logic [3:0] code);
    item_t it;
    it = '0;
    case (code)
      G_S:  begin it.is_store = 1'b1; it.addr = ST_ADDR; it.data = ST_DATA; it.func = ST_FUNC; end
      G_L0: begin it.addr = 32'h040; it.func = 3'd2; it.idx = IW'(5); end
      G_L1: begin it.addr = 32'h100; it.func = 3'd1; it.idx = IW'(2); end
      G_L2: begin it.addr = 32'h1C0; it.func = 3'd4; it.idx = IW'(7); end
      default: it = '0;
    endcase
    return it;
  endfunction

  // Monitor: every request the dcache takes must match the queue head.
  always @(negedge clock) begin
    if (!reset && dc_valid && dc_accept) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got request addr %0h, expected none", dc_addr);
      end else begin
        check("dc_request", 128'({dc_is_store, dc_addr, dc_data, dc_func, dc_idx}),
              128'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_gnt(input string name, input logic [3:0] code);
    @(negedge clock);
    check(name, 128'({st_gnt, ld_gnt}), 128'(code));
  endtask

  task automatic drop_reqs();
    ld_req_valid = '0;
    st_req_valid = 1'b0;
  endtask

  // Hold requests steady with dc_accept=1 for n cycles; codes[4k+3:4k] is the
  // grant expected in cycle k. Then drain and return to IDLE.
  task automatic run_seq(input string name, input logic [NR-1:0] ldv, input logic stv,
                         input int n, input logic [31:0] codes);
    logic [3:0] c;
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      ld_req_valid = ldv;
      st_req_valid = stv;
      dc_accept    = 1'b1;
      c = codes[4*k +: 4];
      exp_q.push_back(exp_item(c));
      check_gnt(name, c);
    end
    @(posedge clock); #1;
    drop_reqs();
    dc_accept = 1'b1;
    @(posedge clock); #1;
    dc_accept = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    ld_req_addr  = {32'h1C0, 32'h100, 32'h040};
    ld_req_func  = {3'd4, 3'd1, 3'd2};
    ld_req_idx   = {IW'(7), IW'(2), IW'(5)};
    st_req_addr  = ST_ADDR;
    st_req_data  = ST_DATA;
    st_req_func  = ST_FUNC;
    ld_req_valid = 3'b111;
    st_req_valid = 1'b1;
    dc_accept    = 1'b0;

    // Reset state: requests present, but no grants and nothing captured.
    @(negedge clock);
    check("reset_grants", 128'({st_gnt, ld_gnt}), 128'(G_NO));
    @(negedge clock);
    check("reset_dc", 128'({dc_valid, dc_is_store, dc_addr, dc_data, dc_func, dc_idx}), 128'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    drop_reqs();

    // Single load, one-cycle latency.
    @(posedge clock); #1;
    ld_req_valid = 3'b010;
    exp_q.push_back(exp_item(G_L1));
    check_gnt("single_load_gnt", G_L1);
    @(posedge clock); #1;
    drop_reqs();
    check("single_load_dc", 128'({dc_valid, dc_is_store, dc_addr, dc_idx}),
          128'({1'b1, 1'b0, 32'h100, IW'(2)}));
    dc_accept = 1'b1;
    check_gnt("single_load_nogrant", G_NO);
    @(posedge clock); #1;
    dc_accept = 1'b0;
    check("single_load_idle", 128'(dc_valid), 128'(0));

    // Store beats a load while starve_cnt is 0.
    @(posedge clock); #1;
    st_req_valid = 1'b1;
    ld_req_valid = 3'b001;
    exp_q.push_back(exp_item(G_S));
    check_gnt("store_vs_load_gnt", G_S);
    @(posedge clock); #1;
    drop_reqs();
    check("store_fields", 128'({dc_is_store, dc_data, dc_idx}), 128'({1'b1, ST_DATA, IW'(0)}));
    dc_accept = 1'b1;
    @(posedge clock); #1;
    dc_accept = 1'b0;

    // Stall: rr_ptr is 2, so load0 is reached by wrapping.
    @(posedge clock); #1;
    ld_req_valid = 3'b001;
    exp_q.push_back(exp_item(G_L0));
    check_gnt("stall_first_gnt", G_L0);
    @(posedge clock); #1;
    ld_req_valid = 3'b100;
    for (int s = 0; s < 3; s++) begin
      check_gnt("stall_no_gnt", G_NO);
      check("stall_hold", 128'({dc_valid, dc_addr, dc_idx}), 128'({1'b1, 32'h040, IW'(5)}));
      @(posedge clock); #1;
    end
    dc_accept = 1'b1;
    exp_q.push_back(exp_item(G_L2));
    check_gnt("stall_release_gnt", G_L2);
    @(posedge clock); #1;
    drop_reqs();
    check("stall_no_bubble", 128'({dc_valid, dc_addr}), 128'({1'b1, 32'h1C0}));
    @(posedge clock); #1;
    dc_accept = 1'b0;

    // Round-robin from rr_ptr=0 with continuous accept.
    run_seq("round_robin", 3'b111, 1'b0, 4, {16'h0, G_L0, G_L2, G_L1, G_L0});

    // Leave rr_ptr=1 and starve_cnt=1 with a store held, then reset mid-cycle.
    @(posedge clock); #1;
    ld_req_valid = 3'b001;
    exp_q.push_back(exp_item(G_L0));
    check_gnt("pre_reset_load", G_L0);
    @(posedge clock); #1;
    st_req_valid = 1'b1;
    dc_accept    = 1'b1;
    check_gnt("pre_reset_store", G_S);
    @(posedge clock); #1;
    drop_reqs();
    dc_accept = 1'b0;
    check("pre_reset_hold", 128'({dc_valid, dc_is_store}), 128'({1'b1, 1'b1}));
    #2;
    reset        = 1'b1;
    ld_req_valid = 3'b111;
    st_req_valid = 1'b1;
    #1;
    check("async_reset_dc", 128'({dc_valid, dc_is_store, dc_addr, dc_data}), 128'(0));
    check("async_reset_gnts", 128'({st_gnt, ld_gnt}), 128'(G_NO));
    @(posedge clock); #1;
    reset = 1'b0;
    drop_reqs();

    // After release: four stores then load0 shows starve_cnt=0 and rr_ptr=0.
    run_seq("post_reset_starve", 3'b111, 1'b1, 5, {12'h0, G_L0, G_S, G_S, G_S, G_S});

    // Starvation with load1: four stores, load1, then store again.
    run_seq("starvation", 3'b010, 1'b1, 6, {8'h0, G_S, G_L1, G_S, G_S, G_S, G_S});

    repeat (2) @(posedge clock);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default `NUM_FU_LOAD, the number of load requesters.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive store wins after which loads get priority.
REQ-003 SHALL have ports, in this order:
  clock  input  1  sole clock, rising edge.
  reset  input  1  asynchronous, active-high.
  ld_req_valid  input  NUM_REQ  per-load request.
  ld_req_addr  input  NUM_REQ x ADDR  load address.
  ld_req_func  input  NUM_REQ x MEM_FUNC  load size/sign.
  ld_req_idx  input  NUM_REQ x `LOAD_Q_INDEX_WIDTH  load-queue index.
  ld_gnt  output  NUM_REQ  one-hot capture pulse.
  st_req_valid  input  1  retiring-store request.
  st_req_addr  input  ADDR  store address.
  st_req_data  input  DATA  store data.
  st_req_func  input  MEM_FUNC  store size.
  st_gnt  output  1  store capture pulse.
  dc_valid  output  1  request to dcache.
  dc_is_store  output  1  1 = store, 0 = load.
  dc_addr  output  ADDR  request address.
  dc_data  output  DATA  store data; 0 for loads.
  dc_func  output  MEM_FUNC  request size/sign.
  dc_idx  output  `LOAD_Q_INDEX_WIDTH  load index; 0 for stores.
  dc_accept  input  1  dcache takes the request this cycle.

Function
REQ-004 SHALL hold one output register (dc_*) and a 2-state FSM: IDLE (dc_valid=0) and HOLD (dc_valid=1).
REQ-005 SHALL define slot free as: state IDLE, or state HOLD with dc_accept=1.
REQ-006 When the slot is free and any request is valid, SHALL capture the winner into dc_* at the next edge and enter or stay in HOLD; otherwise SHALL go to or stay in IDLE.
REQ-007 SHALL raise ld_gnt[i] or st_gnt combinationally in the capture cycle only, at most one bit across all grants.
REQ-008 The requester SHALL treat a grant as consumption; SHALL not grant while the slot is not free.
REQ-009 Latency: a request seen at cycle t with the slot free SHALL appear on dc_* at t+1.
REQ-010 Back-to-back: dc_accept=1 plus a pending request SHALL capture in the same cycle with no bubble.
REQ-011 dc_* SHALL stay stable while in HOLD with dc_accept=0.
REQ-012 Priority: the store SHALL win over loads, unless starve_cnt == STARVE_LIMIT and a load is valid, in which case a load SHALL win.
REQ-013 Load choice: SHALL pick the lowest index i >= rr_ptr with ld_req_valid[i]; if none, SHALL wrap to the lowest valid index below rr_ptr.
REQ-014 On a load grant i, SHALL set rr_ptr = (i+1) mod NUM_REQ; NUM_REQ-1 SHALL wrap to 0.
REQ-015 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each store grant while any load is valid.
REQ-016 starve_cnt SHALL clear to 0 on any load grant, and SHALL hold otherwise.
REQ-017 A deasserted dc_accept in IDLE SHALL be ignored; dc_accept in IDLE SHALL have no effect.
REQ-018 Captured loads SHALL drive dc_data=0 and dc_is_store=0; captured stores SHALL drive dc_idx=0 and dc_is_store=1.

Reset
REQ-019 Reset assertion SHALL immediately force: FSM IDLE, dc_* all 0, rr_ptr 0, starve_cnt 0.
REQ-020 ld_gnt and st_gnt SHALL be 0 while reset is high.
REQ-021 Reset mid-HOLD SHALL drop the held request without signalling the requester.
REQ-022 The first capture after reset deassertion SHALL occur no earlier than the first rising edge with reset low.

Verification
REQ-023 Single load: ld_req_valid=3'b010, addr 0x100, idx 2, IDLE -> ld_gnt=3'b010 at cycle t; at t+1 dc_valid=1, dc_addr=0x100, dc_idx=2, dc_is_store=0.
REQ-024 Store vs load: st_req_valid=1 (0x200, data 0xDEADBEEF) with ld_req_valid=3'b001 and starve_cnt=0 -> st_gnt=1, ld_gnt=0; starve_cnt becomes 1.
REQ-025 Stall: HOLD, dc_accept=0 for 3 cycles, new requests pending -> dc_* unchanged and no grants; dc_accept=1 on cycle 4 -> next request captured with no bubble.
REQ-026 Round-robin: all 3 loads valid continuously, dc_accept=1 every cycle, rr_ptr=0 -> grant order 0,1,2,0.
REQ-027 Starvation: store and load 1 valid continuously, dc_accept=1 every cycle -> 4 store grants, then ld_gnt=3'b010, then starve_cnt=0 and the store wins again.
REQ-028 Async reset: reset pulsed mid-cycle in HOLD -> dc_valid=0 before the next clock edge; rr_ptr=0 and starve_cnt=0 after release.
